// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue between the IFU output register and decode.
// Circular buffer of {instr, tag} entries with first-word-fall-through output,
// an occupancy-based stall to the IFU, flush on PC redirect and a sticky
// overflow flag.
module ifu_fetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned STALL_THRESHOLD = 2,
   parameter int unsigned INSTR_LEN       = 32,
   parameter int unsigned XLEN            = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INSTR_LEN-1:0]     instr_in,
   input  logic                     instr_valid_in,
   input  logic [XLEN-1:0]          instr_tag_in,
   input  logic                     flush,
   input  logic                     decode_ready,
   output logic [INSTR_LEN-1:0]     instr_out,
   output logic                     instr_valid_out,
   output logic [XLEN-1:0]          instr_tag_out,
   output logic                     stall_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 overflow_q, overflow_d;

   // Storage is deliberately left without reset; contents are don't-care while empty.
   logic [INSTR_LEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0]      tag_mem_q   [DEPTH];

   logic full;
   logic pop;
   logic push;
   logic ovf_event;

   // Handshake decode; a full queue still accepts a push when the head leaves the same cycle.
   always_comb begin
      full      = (count_q == CntW'(DEPTH));
      pop       = instr_valid_out & decode_ready & ~flush;
      push      = instr_valid_in & ~flush & (~full | pop);
      ovf_event = instr_valid_in & ~flush & full & ~pop;
   end

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | ovf_event;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry write on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= instr_in;
         tag_mem_q[wr_ptr_q]   <= instr_tag_in;
      end
   end

   // Outputs decoded from registered state only; no input-to-output path.
   always_comb begin
      instr_out       = instr_mem_q[rd_ptr_q];
      instr_tag_out   = tag_mem_q[rd_ptr_q];
      instr_valid_out = (count_q != '0);
      stall_out       = (count_q >= CntW'(STALL_THRESHOLD));
      count           = count_q;
      overflow_err    = overflow_q;
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: the driver pushes expected entries into
// a queue model, a negedge monitor compares DUT state and pops on every dequeue.
module tb_ifu_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TH    = 2;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] tag;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_in;
   logic        instr_valid_in;
   logic [31:0] instr_tag_in;
   logic        flush;
   logic        decode_ready;
   logic [31:0] instr_out;
   logic        instr_valid_out;
   logic [31:0] instr_tag_out;
   logic        stall_out;
   logic [2:0]  count;
   logic        overflow_err;

   ent_t exp_q[$];
   bit   exp_ovf = 1'b0;
   bit   mon_en  = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   max_cnt = 0;

   always #5 clk = ~clk;

   ifu_fetch_queue #(
      .DEPTH           (DEPTH),
      .STALL_THRESHOLD (TH),
      .INSTR_LEN       (32),
      .XLEN            (32)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .instr_in        (instr_in),
      .instr_valid_in  (instr_valid_in),
      .instr_tag_in    (instr_tag_in),
      .flush           (flush),
      .decode_ready    (decode_ready),
      .instr_out       (instr_out),
      .instr_valid_out (instr_valid_out),
      .instr_tag_out   (instr_tag_out),
      .stall_out       (stall_out),
      .count           (count),
      .overflow_err    (overflow_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: compare occupancy/status each cycle, pop scoreboard on dequeue.
   always @(negedge clk) begin
      ent_t e;
      if (mon_en && rst_n) begin
         chk("count", 64'(count), 64'(exp_q.size()));
         chk("valid", 64'(instr_valid_out), 64'(exp_q.size() != 0));
         chk("stall", 64'(stall_out), 64'(exp_q.size() >= TH));
         chk("overflow", 64'(overflow_err), 64'(exp_ovf));
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (instr_valid_out && decode_ready && !flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty actual=valid required=empty");
            end else begin
               e = exp_q.pop_front();
               chk("instr", 64'(instr_out), 64'(e.instr));
               chk("tag", 64'(instr_tag_out), 64'(e.tag));
            end
         end
      end
   end

   // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] tg,
                        input bit fl, input bit rdy, output bit accepted);
      int sz;
      bit pop_e, push_e, ovf_e;
      instr_valid_in = v;
      instr_in       = ins;
      instr_tag_in   = tg;
      flush          = fl;
      decode_ready   = rdy;
      #2;
      sz     = exp_q.size();
      pop_e  = (sz != 0) && rdy && !fl;
      push_e = v && !fl && ((sz < int'(DEPTH)) || pop_e);
      ovf_e  = v && !fl && (sz == int'(DEPTH)) && !pop_e;
      @(negedge clk);
      #2;
      if (fl) exp_q.delete();
      else if (push_e) exp_q.push_back({ins, tg});
      if (ovf_e) exp_ovf = 1'b1;
      accepted = push_e;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] s1_instr [3];
   int          pushes;
   int          cyc;
   bit          acc;

   initial begin
      s1_instr[0] = 32'h0000_0013;
      s1_instr[1] = 32'h0010_0093;
      s1_instr[2] = 32'h0020_0113;
      rst_n          = 1'b0;
      instr_in       = '0;
      instr_valid_in = 1'b0;
      instr_tag_in   = '0;
      flush          = 1'b0;
      decode_ready   = 1'b0;
      #3;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(instr_valid_out), 64'd0);
      chk("rst_stall", 64'(stall_out), 64'd0);
      chk("rst_overflow", 64'(overflow_err), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Three pushes with decode ready: each emerges one cycle later.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, s1_instr[i], 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b1, acc);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("s1_peak", 64'(max_cnt), 64'd1);

      // Fill with decode stalled, then a fifth push overflows.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, $urandom, 32'h8000_0100 + 32'(4 * i), 1'b0, 1'b0, acc);
      chk("s2_ovf_set", 64'(overflow_err), 64'd1);
      chk("s2_count_full", 64'(count), 64'd4);

      // Full queue, simultaneous push and pop: count stays at DEPTH.
      cycle(1'b1, 32'hCAFE_0001, 32'h8000_0200, 1'b0, 1'b1, acc);
      chk("s3_accept", 64'(acc), 64'd1);
      chk("s3_count", 64'(count), 64'd4);
      for (int i = 0; i < 8 && exp_q.size() != 0; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("s3_drain", 64'(count), 64'd0);

      // Three entries, then flush with push and pop requested.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, $urandom, 32'h8000_0300 + 32'(4 * i), 1'b0, 1'b0, acc);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h8000_03F0, 1'b1, 1'b1, acc);
      chk("s4_count", 64'(count), 64'd0);
      chk("s4_valid", 64'(instr_valid_out), 64'd0);
      chk("s4_stall", 64'(stall_out), 64'd0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

      // Asynchronous reset mid-stream with three entries held.
      for (int i = 0; i < 3; i++)
         cycle(1'b1, $urandom, 32'h8000_0400 + 32'(4 * i), 1'b0, 1'b0, acc);
      chk("s6_pre_count", 64'(count), 64'd3);
      instr_valid_in = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("s6_count", 64'(count), 64'd0);
      chk("s6_valid", 64'(instr_valid_out), 64'd0);
      chk("s6_stall", 64'(stall_out), 64'd0);
      chk("s6_overflow", 64'(overflow_err), 64'd0);
      exp_q.delete();
      exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Twenty back-to-back fetches, IFU honouring stall, random decode readiness.
      pushes  = 0;
      cyc     = 0;
      max_cnt = 0;
      while (pushes < 20 && cyc < 300) begin
         cycle(!stall_out, $urandom, 32'h8000_1000 + 32'(4 * pushes), 1'b0,
               1'($urandom_range(0, 1)), acc);
         if (acc) pushes++;
         cyc++;
      end
      chk("s5_pushes", 64'(pushes), 64'd20);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("s5_drain", 64'(count), 64'd0);
      chk("s5_max_le_depth", 64'(max_cnt <= int'(DEPTH)), 64'd1);
      chk("s5_ovf_clear", 64'(overflow_err), 64'd0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
